decode_stage: RTL and testbench

Decode/operand-fetch stage that sits directly upstream of the dual-port register file. It drives the register-file read selects from the incoming instruction and captures the two read operands into a registered decode→execute pipeline slot with a valid/ready handshake. A 16-entry pending-write scoreboard stalls RAW and WAW hazards, and a writeback bypass forwards the register-file write data in the same cycle it is written.

---
 rtl/decode_stage.sv | 182 ++++++++++++++++++
 tb/tb_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: drives register-file read selects, captures
// operands into a registered decode->execute slot, stalls on pending-write hazards.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [3:0]  rf_sel0,
    output logic [3:0]  rf_sel1,
    input  logic [31:0] rf_data0,
    input  logic [31:0] rf_data1,
    input  logic        wb_we,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [3:0]  id_op,
    output logic [3:0]  id_rd,
    output logic        id_we,
    output logic [31:0] id_a,
    output logic [31:0] id_b,
    output logic [31:0] id_imm,
    output logic [31:0] id_pc
);

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    logic [3:0]  op_s;
    logic [3:0]  rd_s;
    logic [3:0]  rs1_s;
    logic [3:0]  rs2_s;
    logic [31:0] imm_s;

    assign op_s  = if_instr[31:28];
    assign rd_s  = if_instr[27:24];
    assign rs1_s = if_instr[23:20];
    assign rs2_s = if_instr[19:16];
    assign imm_s = sext16(if_instr[15:0]);

    assign rf_sel0 = rs1_s;
    assign rf_sel1 = rs2_s;

    logic uses_rs1_s;
    logic uses_rs2_s;
    logic writes_rd_s;
    logic is_imm_s;

    // Instruction class: which sources are read and whether rd is written
    always_comb begin
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        is_imm_s    = 1'b0;
        case (op_s) inside
            [4'h0:4'h7]: begin
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            [4'h8:4'hB]: begin
                uses_rs1_s  = 1'b1;
                writes_rd_s = 1'b1;
                is_imm_s    = 1'b1;
            end
            4'hC, 4'hD: begin
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b1;
            end
            4'hE: begin
                uses_rs1_s  = 1'b1;
                writes_rd_s = 1'b1;
            end
            default: begin
                uses_rs1_s  = 1'b0;
                uses_rs2_s  = 1'b0;
                writes_rd_s = 1'b0;
                is_imm_s    = 1'b0;
            end
        endcase
    end

    logic [15:0] pending_r;
    logic        id_valid_r;
    logic [3:0]  id_op_r;
    logic [3:0]  id_rd_r;
    logic        id_we_r;
    logic [31:0] id_a_r;
    logic [31:0] id_b_r;
    logic [31:0] id_imm_r;
    logic [31:0] id_pc_r;

    // Writeback bypass: the value being written this cycle wins over the stale read
    logic        byp0_s;
    logic        byp1_s;
    logic [31:0] opa_s;
    logic [31:0] opb_s;

    assign byp0_s = wb_we && (wb_rd == rs1_s);
    assign byp1_s = wb_we && (wb_rd == rs2_s);
    assign opa_s  = byp0_s ? wb_data : rf_data0;
    assign opb_s  = byp1_s ? wb_data : rf_data1;

    logic raw0_s;
    logic raw1_s;
    logic waw_s;
    logic hazard_s;
    logic free_s;
    logic if_ready_s;
    logic accept_s;

    assign raw0_s     = uses_rs1_s && pending_r[rs1_s] && !byp0_s;
    assign raw1_s     = uses_rs2_s && pending_r[rs2_s] && !byp1_s;
    assign waw_s      = writes_rd_s && pending_r[rd_s];
    assign hazard_s   = raw0_s || raw1_s || waw_s;
    assign free_s     = !id_valid_r || id_ready;
    assign if_ready_s = free_s && !hazard_s && !flush && !reset;
    assign accept_s   = if_valid && if_ready_s;
    assign if_ready   = if_ready_s;

    // The WAW stall guarantees set and clear never target the same bit together
    logic [15:0] clr_wb_s;
    logic [15:0] clr_fl_s;
    logic [15:0] set_s;
    logic [15:0] pending_nxt_s;

    assign clr_wb_s      = wb_we ? onehot16(wb_rd) : 16'h0000;
    assign clr_fl_s      = (flush && id_valid_r && id_we_r) ? onehot16(id_rd_r) : 16'h0000;
    assign set_s         = (accept_s && writes_rd_s) ? onehot16(rd_s) : 16'h0000;
    assign pending_nxt_s = (pending_r & ~clr_wb_s & ~clr_fl_s) | set_s;

    // Scoreboard and decode->execute slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= 16'h0000;
            id_valid_r <= 1'b0;
            id_op_r    <= 4'h0;
            id_rd_r    <= 4'h0;
            id_we_r    <= 1'b0;
            id_a_r     <= 32'h0000_0000;
            id_b_r     <= 32'h0000_0000;
            id_imm_r   <= 32'h0000_0000;
            id_pc_r    <= 32'h0000_0000;
        end else begin
            pending_r <= pending_nxt_s;
            if (flush) begin
                id_valid_r <= 1'b0;
            end else if (accept_s) begin
                id_valid_r <= 1'b1;
                id_op_r    <= op_s;
                id_rd_r    <= rd_s;
                id_we_r    <= writes_rd_s;
                id_a_r     <= opa_s;
                id_b_r     <= is_imm_s ? imm_s : opb_s;
                id_imm_r   <= imm_s;
                id_pc_r    <= if_pc;
            end else if (id_ready) begin
                id_valid_r <= 1'b0;
            end else begin
                id_valid_r <= id_valid_r;
            end
        end
    end

    assign id_valid = id_valid_r;
    assign id_op    = id_op_r;
    assign id_rd    = id_rd_r;
    assign id_we    = id_we_r;
    assign id_a     = id_a_r;
    assign id_b     = id_b_r;
    assign id_imm   = id_imm_r;
    assign id_pc    = id_pc_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a register-file model feeds the read ports,
// expected slot contents are queued at issue and compared on each handshake.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [3:0]  rf_sel0;
    logic [3:0]  rf_sel1;
    logic [31:0] rf_data0;
    logic [31:0] rf_data1;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_op;
    logic [3:0]  id_rd;
    logic        id_we;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic [31:0] id_imm;
    logic [31:0] id_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    logic [31:0] rf_model [16] = '{default: 32'h0000_0000};

    decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .rf_sel0(rf_sel0), .rf_sel1(rf_sel1), .rf_data0(rf_data0), .rf_data1(rf_data1),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_rd(id_rd),
        .id_we(id_we), .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc(id_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign rf_data0 = rf_model[rf_sel0];
    assign rf_data1 = rf_model[rf_sel1];

    always @(posedge clk) begin
        if (wb_we) rf_model[wb_rd] <= wb_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [31:0] opnd(input logic [3:0] rs);
        return (wb_we && wb_rd == rs) ? wb_data : rf_model[rs];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [3:0] op;
        op    = ins[31:28];
        e.op  = op;
        e.rd  = ins[27:24];
        e.we  = (op <= 4'hB) || (op == 4'hE);
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.a   = opnd(ins[23:20]);
        e.b   = (op >= 4'h8 && op <= 4'hB) ? e.imm : opnd(ins[19:16]);
        e.pc  = pc;
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic push_exp();
        q.push_back(model(if_instr, if_pc));
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the slot on every handshake; a flushed slot is dropped
    always @(negedge clk) begin
        exp_t e;
        if (!reset && id_valid && (id_ready || flush)) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_id_valid", {31'h0, id_valid}, 32'h0000_0000);
            end else begin
                e = q.pop_front();
                if (!flush) begin
                    chk("sb_op",  {28'h0, id_op}, {28'h0, e.op});
                    chk("sb_rd",  {28'h0, id_rd}, {28'h0, e.rd});
                    chk("sb_we",  {31'h0, id_we}, {31'h0, e.we});
                    chk("sb_a",   id_a,   e.a);
                    chk("sb_b",   id_b,   e.b);
                    chk("sb_imm", id_imm, e.imm);
                    chk("sb_pc",  id_pc,  e.pc);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b1;
        wb_we    = 1'b0;
        wb_rd    = 4'h0;
        wb_data  = 32'h0000_0000;
        issue(mk(4'h0, 4'h1, 4'h2, 4'h4, 16'h0000), 32'h0000_0040);

        // Reset held two cycles with an instruction offered
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("reset_if_ready", {31'h0, if_ready}, 32'h0);
            chk("reset_id_valid", {31'h0, id_valid}, 32'h0);
            chk("reset_id_a", id_a, 32'h0);
            chk("reset_id_pc", id_pc, 32'h0);
            cyc();
        end
        reset = 1'b0;
        push_exp();
        mid();
        chk("first_accept", {31'h0, if_ready}, 32'h1);
        cyc();

        // Preload r3=30, r10=100 and retire r1 through the writeback port
        if_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'd30;
        cyc();
        wb_rd = 4'd10; wb_data = 32'd100;
        mid();
        chk("consume_clears_valid", {31'h0, id_valid}, 32'h0);
        cyc();
        wb_rd = 4'd1; wb_data = 32'd11;
        cyc();
        wb_we = 1'b0;

        // Plain reg-reg fetch
        issue(mk(4'h0, 4'd5, 4'd3, 4'd10, 16'h0012), 32'h0000_0100);
        push_exp();
        mid();
        chk("plain_if_ready", {31'h0, if_ready}, 32'h1);
        cyc();

        // RAW on r5, then release through the bypass
        issue(mk(4'h1, 4'd6, 4'd5, 4'd3, 16'h0000), 32'h0000_0104);
        mid();
        chk("raw_stall", {31'h0, if_ready}, 32'h0);
        cyc();
        mid();
        chk("raw_stall_hold", {31'h0, if_ready}, 32'h0);
        chk("raw_slot_empty", {31'h0, id_valid}, 32'h0);
        cyc();
        wb_we = 1'b1; wb_rd = 4'd5; wb_data = 32'd77;
        push_exp();
        mid();
        chk("bypass_accept", {31'h0, if_ready}, 32'h1);
        cyc();
        wb_we = 1'b0;

        // Immediate form, then a read of the now-retired r5 back to back
        issue(mk(4'h8, 4'd8, 4'd3, 4'd0, 16'hFFFE), 32'h0000_0108);
        push_exp();
        mid();
        chk("imm_if_ready", {31'h0, if_ready}, 32'h1);
        cyc();
        issue(mk(4'h3, 4'd9, 4'd5, 4'd10, 16'h0000), 32'h0000_010C);
        push_exp();
        mid();
        chk("pending_cleared_by_wb", {31'h0, if_ready}, 32'h1);
        cyc();

        // WAW on r6 stalls; a nop naming r6 does not
        issue(mk(4'h0, 4'd6, 4'd3, 4'd3, 16'h0000), 32'h0000_0110);
        mid();
        chk("waw_stall", {31'h0, if_ready}, 32'h0);
        cyc();
        issue(mk(4'hF, 4'd0, 4'd6, 4'd6, 16'h0000), 32'h0000_0114);
        push_exp();
        mid();
        chk("nop_no_stall", {31'h0, if_ready}, 32'h1);
        cyc();
        if_valid = 1'b0;
        cyc();

        // Backpressure: first held stable, second waits
        id_ready = 1'b0;
        issue(mk(4'h0, 4'd12, 4'd3, 4'd10, 16'h0000), 32'h0000_0200);
        push_exp();
        mid();
        chk("bp_first_accept", {31'h0, if_ready}, 32'h1);
        cyc();
        issue(mk(4'h1, 4'd13, 4'd10, 4'd3, 16'h0000), 32'h0000_0204);
        mid();
        chk("bp_stall", {31'h0, if_ready}, 32'h0);
        chk("bp_hold_pc", id_pc, 32'h0000_0200);
        cyc();
        mid();
        chk("bp_stall_hold", {31'h0, if_ready}, 32'h0);
        chk("bp_hold_pc2", id_pc, 32'h0000_0200);
        chk("bp_hold_a", id_a, 32'd30);
        cyc();
        id_ready = 1'b1;
        push_exp();
        mid();
        chk("bp_release", {31'h0, if_ready}, 32'h1);
        cyc();
        if_valid = 1'b0;
        mid();
        chk("bp_second_loaded", id_pc, 32'h0000_0204);
        cyc();

        // Flush squashes a held writer of r7 and blocks the incoming reader
        id_ready = 1'b0;
        issue(mk(4'h0, 4'd7, 4'd3, 4'd3, 16'h0000), 32'h0000_0300);
        push_exp();
        mid();
        chk("flush_setup_accept", {31'h0, if_ready}, 32'h1);
        cyc();
        flush = 1'b1;
        issue(mk(4'h0, 4'd14, 4'd7, 4'd3, 16'h0000), 32'h0000_0304);
        mid();
        chk("flush_blocks_accept", {31'h0, if_ready}, 32'h0);
        chk("flush_held_rd", {28'h0, id_rd}, 32'd7);
        cyc();
        flush = 1'b0;
        id_ready = 1'b1;
        push_exp();
        mid();
        chk("flush_clears_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_clears_pending", {31'h0, if_ready}, 32'h1);
        cyc();
        if_valid = 1'b0;
        cyc();

        // Reset while a stalled instruction waits behind a full slot
        id_ready = 1'b0;
        issue(mk(4'h0, 4'd2, 4'd3, 4'd3, 16'h0000), 32'h0000_0400);
        push_exp();
        cyc();
        issue(mk(4'h0, 4'd15, 4'd6, 4'd8, 16'h0000), 32'h0000_0404);
        mid();
        chk("stall_before_reset", {31'h0, if_ready}, 32'h0);
        cyc();
        reset = 1'b1;
        q.delete();
        mid();
        chk("reset_mid_if_ready", {31'h0, if_ready}, 32'h0);
        cyc();
        reset = 1'b0;
        push_exp();
        mid();
        chk("reset_drops_slot", {31'h0, id_valid}, 32'h0);
        chk("reset_clears_pending", {31'h0, if_ready}, 32'h1);
        cyc();
        if_valid = 1'b0;
        id_ready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
